// File: rtl/featuremap_stream_source.sv
// Raster-order feature-map reader: RAM words out as a valid-qualified
// pixel stream with sof/eol framing, one frame per start pulse.
module featuremap_stream_source #(
  parameter int DATA_WIDTH = 1024,
  parameter int IMG_SIZE   = 104,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } tag_t;

  state_t                state;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [ADDR_WIDTH-1:0] addr;
  tag_t                  s1;
  logic                  issue;
  logic                  last;

  assign issue     = (state == S_ISSUE) && !stall;
  assign last      = (row == LAST) && (col == LAST);
  assign mem_rd_en = issue;
  assign mem_addr  = addr;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      addr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
            addr  <= '0;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            addr <= addr + 1'b1;
            if (col == LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Stage 2 empties on this same edge, so done lands right
          // after the final valid_out.
          if (!s1.valid) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1        <= '0;
      valid_out <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      data_out  <= '0;
    end else begin
      s1.valid  <= issue;
      s1.sof    <= issue && (addr == '0);
      s1.eol    <= issue && (col == LAST);
      valid_out <= s1.valid;
      sof       <= s1.sof;
      eol       <= s1.eol;
      if (s1.valid) data_out <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_featuremap_stream_source.sv
// Directed bench: 4x4 frames (plain, stall, restart, reset, start at
// done) plus one full 104x104 frame.
module tb_featuremap_stream_source;

  localparam int DW = 1024;
  localparam int AW = 14;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [31:0] hi;
    logic        busy;
    logic        sof;
    logic        eol;
  } ev_t;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start4, stall4;
  logic          rd4, v4, sof4, eol4, busy4, done4;
  logic [AW-1:0] addr4;
  logic [DW-1:0] rdata4, d4;
  logic          start_b, stall_b;
  logic          rd_b, v_b, sof_b, eol_b, busy_b, done_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b, d_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  ev_t issue_q[$];
  ev_t pix_q[$];
  ev_t done_q[$];

  int b_icnt = 0, b_vcnt = 0, b_err = 0;
  int b_eol_n = 0, b_sof_n = 0, b_done_n = 0;
  int b_last_addr = -1, b_first_v = -1, b_last_v = -1, b_done_cyc = -1;

  featuremap_stream_source #(.IMG_SIZE(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .start(start4), .stall(stall4),
    .mem_rd_en(rd4), .mem_addr(addr4), .mem_rd_data(rdata4),
    .data_out(d4), .valid_out(v4), .sof(sof4), .eol(eol4),
    .busy(busy4), .done(done4)
  );

  featuremap_stream_source dutb (
    .Clk(Clk), .Rst(Rst), .start(start_b), .stall(stall_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rd_data(rdata_b),
    .data_out(d_b), .valid_out(v_b), .sof(sof_b), .eol(eol_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    if (rd4)  rdata4  <= {32{32'(addr4)}};
    if (rd_b) rdata_b <= {32{32'(addr_b)}};
  end

  always @(negedge Clk) begin
    if (rd4)
      issue_q.push_back('{cyc, 32'(addr4), 32'd0, busy4, 1'b0, 1'b0});
    if (v4)
      pix_q.push_back('{cyc, d4[31:0], d4[1023:992], busy4, sof4, eol4});
    if (done4)
      done_q.push_back('{cyc, 32'd0, 32'd0, busy4, 1'b0, 1'b0});
  end

  always @(negedge Clk) begin
    if (rd_b) begin
      if (32'(addr_b) != b_icnt) b_err++;
      b_icnt++;
      b_last_addr = 32'(addr_b);
    end
    if (v_b) begin
      if (d_b[31:0] != b_vcnt) b_err++;
      if (b_first_v < 0) b_first_v = cyc;
      b_last_v = cyc;
      b_vcnt++;
      if (eol_b) b_eol_n++;
      if (sof_b) b_sof_n++;
    end
    if (done_b) begin
      b_done_n++;
      b_done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start4 = 1'b1;
    s = cyc;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget);
    int k = 0;
    while (done_q.size() <= db && k < budget) begin
      tick();
      k++;
    end
    check("done_wait", done_q.size() > db, 1);
  endtask

  // s: cycle during which start was high; gap of gap_len stall
  // cycles is inserted before issue number gap_at.
  task automatic verify_frame(input int s, input int gap_at,
                              input int gap_len, input int ib,
                              input int pb, input int db);
    int ic;
    check("issue_count", issue_q.size() - ib, 16);
    check("pixel_count", pix_q.size() - pb, 16);
    check("done_count", done_q.size() - db, 1);
    if (issue_q.size() - ib == 16 && pix_q.size() - pb == 16) begin
      check("busy_first_issue", issue_q[ib].busy, 1);
      check("busy_last_pix", pix_q[pb+15].busy, 1);
      for (int i = 0; i < 16; i++) begin
        ic = s + 1 + i + ((i >= gap_at) ? gap_len : 0);
        check("issue_addr", issue_q[ib+i].val, i);
        check("issue_cyc", issue_q[ib+i].cyc, ic);
        check("pix_ch0", pix_q[pb+i].val, i);
        check("pix_ch31", pix_q[pb+i].hi, i);
        check("pix_cyc", pix_q[pb+i].cyc, ic + 2);
        check("pix_sof", pix_q[pb+i].sof, i == 0);
        check("pix_eol", pix_q[pb+i].eol, (i % 4) == 3);
      end
    end
    if (done_q.size() > db) begin
      check("done_cyc", done_q[db].cyc, s + 19 + gap_len);
      check("busy_at_done", done_q[db].busy, 0);
    end
  endtask

  initial begin
    int s, d, ib, pb, db, k;
    Rst = 1'b0;
    start4 = 1'b0;
    stall4 = 1'b0;
    start_b = 1'b0;
    stall_b = 1'b0;
    repeat (3) tick();
    check("rst_valid", v4, 0);
    check("rst_rd_en", rd4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_sof_eol", {sof4, eol4}, 0);
    check("rst_data", d4[31:0], 0);
    check("rst_addr", addr4, 0);
    Rst = 1'b1;
    tick();

    // plain frame, with stall high in idle
    stall4 = 1'b1;
    repeat (2) tick();
    stall4 = 1'b0;
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    wait_done(db, 60);
    repeat (3) tick();
    verify_frame(s, 16, 0, ib, pb, db);

    // stall for 3 cycles after the 5th issue
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    while (cyc < s + 6) tick();
    stall4 = 1'b1;
    while (cyc < s + 9) tick();
    stall4 = 1'b0;
    wait_done(db, 60);
    repeat (3) tick();
    verify_frame(s, 5, 3, ib, pb, db);

    // start re-pulsed at the 8th issue
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    while (cyc < s + 8) tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done(db, 60);
    repeat (3) tick();
    verify_frame(s, 16, 0, ib, pb, db);

    // reset mid-frame after addr 6
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    while (cyc < s + 8) tick();
    Rst = 1'b0;
    #3;
    check("midrst_valid", v4, 0);
    check("midrst_rd_en", rd4, 0);
    check("midrst_busy", busy4, 0);
    check("midrst_sof_eol", {sof4, eol4}, 0);
    check("midrst_data", d4[31:0], 0);
    tick();
    Rst = 1'b1;
    repeat (25) tick();
    check("midrst_issues", issue_q.size() - ib, 7);
    check("midrst_pixels", pix_q.size() - pb, 5);
    check("midrst_no_done", done_q.size() - db, 0);
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    wait_done(db, 60);
    repeat (3) tick();
    verify_frame(s, 16, 0, ib, pb, db);

    // start on the done cycle is ignored, one cycle later accepted
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    pulse_start(s);
    d = s + 19;
    k = 0;
    while (cyc < d && k < 60) begin
      tick();
      k++;
    end
    start4 = 1'b1;
    tick();
    check("busy_after_done", busy4, 0);
    verify_frame(s, 16, 0, ib, pb, db);
    ib = issue_q.size(); pb = pix_q.size(); db = done_q.size();
    s = cyc;
    tick();
    start4 = 1'b0;
    check("busy_new_frame", busy4, 1);
    wait_done(db, 60);
    repeat (3) tick();
    verify_frame(s, 16, 0, ib, pb, db);

    // full-size frame
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 0;
    while (b_done_n == 0 && k < 11000) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check("big_valids", b_vcnt, 10816);
    check("big_issues", b_icnt, 10816);
    check("big_last_addr", b_last_addr, 10815);
    check("big_eol", b_eol_n, 104);
    check("big_sof", b_sof_n, 1);
    check("big_done", b_done_n, 1);
    check("big_order", b_err, 0);
    check("big_span", b_last_v - b_first_v, 10815);
    check("big_done_cyc", b_done_cyc, b_last_v + 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/featuremap_stream_source.md
Name: featuremap_stream_source

Overview:
- Reads a stored, channel-packed feature map from on-chip RAM, one word per pixel, in raster order (row-major, column fastest).
- Emits the words as a valid-qualified pixel stream on the wide data_in/valid_in interface that a layer's per-channel Conv2D3x3 bank consumes.
- It is the producer end of that stream. One frame is sent per start pulse.

Parameters:
- DATA_WIDTH, 1024, pixel word width: 32 channels x 32-bit IEEE-754 float; channel k occupies bits [32k+31:32k].
- IMG_SIZE, 104, feature map height and width in pixels (square map).
- ADDR_WIDTH, 14, RAM address width; must satisfy 2^ADDR_WIDTH >= IMG_SIZE*IMG_SIZE.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a frame; ignored unless idle.
- stall  in  1  while high, no new RAM read is issued.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM read address, row*IMG_SIZE+col.
- mem_rd_data  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_en.
- data_out  out  DATA_WIDTH  pixel word to the convolution bank.
- valid_out  out  1  data_out carries a pixel this cycle.
- sof  out  1  high with valid_out on pixel (0,0).
- eol  out  1  high with valid_out on the last pixel of each row (col = IMG_SIZE-1).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final pixel is emitted.

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0, data_out 0, state IDLE, row/col counters 0, pipeline valid flags cleared. An in-flight frame is abandoned; no done pulse follows.
- States:
  - IDLE: start=1 -> ISSUE; clear row/col.
  - ISSUE: each cycle with stall=0, assert mem_rd_en with mem_addr = row*IMG_SIZE+col, then advance col. At col = IMG_SIZE-1, col wraps to 0 and row increments. The issue of (IMG_SIZE-1, IMG_SIZE-1) moves to DRAIN.
  - DRAIN: no reads; wait until both pipeline stages are empty, then go to DONE.
  - DONE: assert done for 1 cycle -> IDLE.
- busy is 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.
- mem_addr is driven from a running address register that increments by 1 per issue, not from a multiplier; it equals row*IMG_SIZE+col by construction.
- Pipeline latency: read issued at cycle t -> mem_rd_data at t+1 -> registered onto data_out with valid_out=1 at t+2.
- sof and eol are carried through the same two-stage pipeline and stay aligned with valid_out.
- stall gates issue only. Reads already issued complete and still appear on valid_out; there are at most 2 after stall rises. With stall=0 throughout, valid_out is continuous for IMG_SIZE^2 cycles.
- When valid_out=0, data_out holds its last value.
- Exactly IMG_SIZE^2 valid_out cycles per frame; no address is repeated or skipped.
- Final address is IMG_SIZE^2-1. done asserts the cycle after the last valid_out.
- start while busy or in DONE is ignored. start in the same cycle as the done pulse is ignored; start is accepted again the cycle after.
- stall asserted in IDLE has no effect. stall held high indefinitely in ISSUE freezes the counters; the frame resumes seamlessly when stall falls.

Test Plan:
- IMG_SIZE=4, start pulse, stall=0, RAM word i = {32{i[31:0]}} -> mem_addr 0..15 on consecutive cycles; valid_out for 16 consecutive cycles starting 2 cycles after the first mem_rd_en; data_out channel 0 = 0..15; sof with pixel 0; eol with pixels 3, 7, 11, 15; done 1 cycle after pixel 15; busy falls with done.
- IMG_SIZE=4, stall high for 3 cycles after the 5th issue -> exactly 2 further valid_out (addr 3, 4), then a 3-cycle gap; stream resumes at addr 5; total 16 valids in order.
- start re-pulsed at the 8th issue -> ignored; addresses continue 8..15; a single done.
- Rst low for 1 cycle mid-frame (after addr 6) -> all outputs 0 immediately; no done. A following start restarts at addr 0 with sof.
- Default IMG_SIZE=104 -> 10816 valids; last mem_addr 10815; eol count 104; one sof; one done.
- start coincident with the done pulse -> ignored; start one cycle later -> new frame begins at addr 0.
